// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register for the 64-bit ALU with XZR/immediate/bypass operand
// select, ALUOp decode and a valid/ready handshake with stall and flush.
module alu_issue_stage #(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic [AW-1:0] i_rs2_addr,
    input  logic [DW-1:0] i_rs1_data,
    input  logic [DW-1:0] i_rs2_data,
    input  logic [DW-1:0] i_imm,
    input  logic          i_alu_src,
    input  logic [1:0]    i_alu_op,
    input  logic [10:0]   i_opcode,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    input  logic          i_flush,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_src1,
    output logic [DW-1:0] o_src2,
    output logic [3:0]    o_alu_ctrl,
    output logic [AW-1:0] o_out_rd,
    output logic          o_illegal
);
    localparam logic [AW-1:0] XZR = '1;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    logic          r_out_valid;
    logic [DW-1:0] r_src1;
    logic [DW-1:0] r_src2;
    logic [3:0]    r_alu_ctrl;
    logic [AW-1:0] r_out_rd;
    logic          r_illegal;
    logic [AW-1:0] r_rs1_addr;
    logic [AW-1:0] r_rs2_addr;
    logic          r_alu_src;

    logic          w_capture;
    logic [DW-1:0] w_src1;
    logic [DW-1:0] w_src2;
    logic          w_r_legal;
    logic [3:0]    w_r_ctrl;
    logic [3:0]    w_alu_ctrl;
    logic          w_illegal;
    logic          w_hold_wb1;
    logic          w_hold_wb2;

    always_comb begin
        o_in_ready = !r_out_valid | i_out_ready | i_flush;
        w_capture  = i_in_valid & o_in_ready & !i_flush;
        // XZR wins over bypass; the immediate path ignores both
        w_src1 = (i_rs1_addr == XZR) ? '0 :
                 (i_wb_en && i_wb_addr == i_rs1_addr) ? i_wb_data : i_rs1_data;
        w_src2 = i_alu_src ? i_imm :
                 (i_rs2_addr == XZR) ? '0 :
                 (i_wb_en && i_wb_addr == i_rs2_addr) ? i_wb_data : i_rs2_data;
        w_r_legal = (i_opcode == OPC_ADD) | (i_opcode == OPC_SUB) |
                    (i_opcode == OPC_AND) | (i_opcode == OPC_ORR);
        w_r_ctrl = (i_opcode == OPC_SUB) ? 4'b0110 :
                   (i_opcode == OPC_AND) ? 4'b0000 :
                   (i_opcode == OPC_ORR) ? 4'b0001 : 4'b0010;
        w_alu_ctrl = (i_alu_op == 2'b01) ? 4'b0111 :
                     (i_alu_op == 2'b10) ? w_r_ctrl : 4'b0010;
        w_illegal = (i_alu_op == 2'b11) | ((i_alu_op == 2'b10) & !w_r_legal);
        w_hold_wb1 = i_wb_en & (i_wb_addr != XZR) & (i_wb_addr == r_rs1_addr);
        w_hold_wb2 = i_wb_en & (i_wb_addr != XZR) & (i_wb_addr == r_rs2_addr) & !r_alu_src;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_alu_ctrl  <= 4'b0000;
            r_out_rd    <= '0;
            r_illegal   <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_alu_src   <= 1'b0;
        end else begin
            r_out_valid <= i_flush ? 1'b0 : w_capture ? 1'b1 : i_out_ready ? 1'b0 : r_out_valid;
            if (w_capture) begin
                r_src1     <= w_src1;
                r_src2     <= w_src2;
                r_alu_ctrl <= w_alu_ctrl;
                r_out_rd   <= i_rd_addr;
                r_illegal  <= w_illegal;
                r_rs1_addr <= i_rs1_addr;
                r_rs2_addr <= i_rs2_addr;
                r_alu_src  <= i_alu_src;
            end else begin
                // late write-back refreshes the operands of a held beat
                if (w_hold_wb1)
                    r_src1 <= i_wb_data;
                if (w_hold_wb2)
                    r_src2 <= i_wb_data;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_src1      = r_src1;
    assign o_src2      = r_src2;
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_out_rd    = r_out_rd;
    assign o_illegal   = r_illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed literal checks plus randomized traffic compared
// every cycle against a beat-level model of the issue stage.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, alu_src, wb_en, flush, out_valid, out_ready, illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr, out_rd;
    logic [63:0] rs1_data, rs2_data, imm, wb_data, src1, src2;
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic [3:0]  alu_ctrl;

    int total = 0;
    int bad = 0;

    logic [10:0] opcs [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    logic [3:0]  ctls [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    logic [4:0]  addr_pool [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};

    // model of the beat currently held at the stage output
    bit          m_v, m_as, m_ill;
    logic [63:0] m_s1, m_s2;
    logic [3:0]  m_c;
    logic [4:0]  m_rd, m_a1, m_a2;

    always #5 clk = ~clk;

    alu_issue_stage #(.DW(64), .AW(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
        .i_imm(imm), .i_alu_src(alu_src), .i_alu_op(alu_op), .i_opcode(opcode), .i_rd_addr(rd_addr),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_flush(flush),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_src1(src1), .o_src2(src2),
        .o_alu_ctrl(alu_ctrl), .o_out_rd(out_rd), .o_illegal(illegal)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] decode(input logic [1:0] op, input logic [10:0] opc);
        if (op == 2'b00) return {1'b0, 4'b0010};
        if (op == 2'b01) return {1'b0, 4'b0111};
        if (op == 2'b11) return {1'b1, 4'b0010};
        for (int i = 0; i < 4; i++)
            if (opc == opcs[i]) return {1'b0, ctls[i]};
        return {1'b1, 4'b0010};
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] a, input logic [63:0] d);
        if (a == 5'd31) return 64'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return d;
    endfunction

    task automatic model_reset();
        m_v = 0; m_as = 0; m_ill = 0; m_s1 = 0; m_s2 = 0; m_c = 0; m_rd = 0; m_a1 = 0; m_a2 = 0;
    endtask

    task automatic model_step();
        bit rdy, cap;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = !m_v || out_ready || flush;
        cap = in_valid && rdy && !flush;
        if (cap) begin
            m_s1 = operand(rs1_addr, rs1_data);
            m_s2 = alu_src ? imm : operand(rs2_addr, rs2_data);
            {m_ill, m_c} = decode(alu_op, opcode);
            m_rd = rd_addr; m_a1 = rs1_addr; m_a2 = rs2_addr; m_as = alu_src;
        end else if (wb_en && wb_addr != 5'd31) begin
            if (m_a1 == wb_addr) m_s1 = wb_data;
            if (!m_as && m_a2 == wb_addr) m_s2 = wb_data;
        end
        m_v = flush ? 0 : cap ? 1 : out_ready ? 0 : m_v;
    endtask

    // called at a falling edge with inputs already set for the coming rising edge
    task automatic cycle();
        #1;
        chk("in_ready", in_ready, !m_v || out_ready || flush);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("out_valid", out_valid, m_v);
        if (m_v) begin
            chk("src1", src1, m_s1);
            chk("src2", src2, m_s2);
            chk("alu_ctrl", alu_ctrl, m_c);
            chk("out_rd", out_rd, m_rd);
            chk("illegal", illegal, m_ill);
        end
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; imm = 0; alu_src = 0;
        alu_op = 0; opcode = 0; rd_addr = 0;
    endtask

    task automatic beat(input logic [1:0] op, input logic [10:0] opc, input logic [4:0] a1,
                        input logic [63:0] d1, input logic [4:0] a2, input logic [63:0] d2,
                        input logic as, input logic [63:0] im, input logic [4:0] rd);
        in_valid = 1; alu_op = op; opcode = opc; rs1_addr = a1; rs1_data = d1;
        rs2_addr = a2; rs2_data = d2; alu_src = as; imm = im; rd_addr = rd;
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("reset_valid", out_valid, 0);
        chk("reset_ctrl", alu_ctrl, 0);
        chk("reset_src1", src1, 0);

        beat(2'b10, 11'b11001011000, 5'd1, 64'd9, 5'd2, 64'd4, 0, 64'd0, 5'd4);
        cycle();
        chk("sub_ctrl", alu_ctrl, 4'b0110);
        chk("sub_src1", src1, 64'd9);
        chk("sub_src2", src2, 64'd4);
        chk("sub_ill", illegal, 0);

        beat(2'b00, 11'd0, 5'd31, 64'd5, 5'd2, 64'd4, 1, 64'hFFFF_FFFF_FFFF_FFF8, 5'd9);
        cycle();
        chk("xzr_src1", src1, 64'd0);
        chk("imm_src2", src2, 64'hFFFF_FFFF_FFFF_FFF8);

        beat(2'b00, 11'd0, 5'd1, 64'd2, 5'd3, 64'd1, 0, 64'd0, 5'd1);
        wb_en = 1; wb_addr = 5'd3; wb_data = 64'd77;
        cycle();
        chk("bypass_src2", src2, 64'd77);
        wb_addr = 5'd31;
        cycle();
        chk("wb31_src2", src2, 64'd1);
        wb_en = 0;

        beat(2'b10, 11'b10001011000, 5'd5, 64'd11, 5'd6, 64'd22, 0, 64'd0, 5'd7);
        cycle();
        out_ready = 0;
        beat(2'b10, 11'b10001010000, 5'd1, 64'd1000, 5'd2, 64'd2000, 0, 64'd0, 5'd8);
        cycle();
        chk("stall_ready", in_ready, 0);
        chk("stall_src1", src1, 64'd11);
        wb_en = 1; wb_addr = 5'd5; wb_data = 64'd123;
        cycle();
        wb_en = 0;
        chk("stall_wb_src1", src1, 64'd123);
        chk("stall_wb_src2", src2, 64'd22);
        cycle();
        chk("stall_hold", src1, 64'd123);
        out_ready = 1;
        cycle();
        chk("drain_src1", src1, 64'd1000);
        chk("drain_ctrl", alu_ctrl, 4'b0000);
        chk("drain_rd", out_rd, 5'd8);

        out_ready = 0;
        cycle();
        rst_n = 0;
        #2;
        chk("areset_valid", out_valid, 0);
        chk("areset_ctrl", alu_ctrl, 0);
        chk("areset_src1", src1, 0);
        chk("areset_src2", src2, 0);
        model_reset();
        cycle();
        rst_n = 1;
        idle();

        out_ready = 0;
        beat(2'b10, 11'b10001011000, 5'd1, 64'd3, 5'd2, 64'd4, 0, 64'd0, 5'd2);
        cycle();
        chk("pre_flush_valid", out_valid, 1);
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 0);
        flush = 0; out_ready = 1;
        beat(2'b11, 11'b10001011000, 5'd1, 64'd3, 5'd2, 64'd4, 0, 64'd0, 5'd2);
        cycle();
        chk("op11_ctrl", alu_ctrl, 4'b0010);
        chk("op11_ill", illegal, 1);
        beat(2'b10, 11'b10101010000, 5'd1, 64'd3, 5'd2, 64'd4, 0, 64'd0, 5'd2);
        cycle();
        chk("orr_ctrl", alu_ctrl, 4'b0001);
        chk("orr_ill", illegal, 0);
        beat(2'b10, 11'b11111111111, 5'd1, 64'd3, 5'd2, 64'd4, 0, 64'd0, 5'd2);
        cycle();
        chk("badopc_ill", illegal, 1);
        beat(2'b01, 11'd0, 5'd1, 64'd3, 5'd2, 64'd4, 0, 64'd0, 5'd2);
        cycle();
        chk("cbz_ctrl", alu_ctrl, 4'b0111);

        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 19) == 0);
            wb_en = $urandom_range(0, 1);
            wb_addr = addr_pool[$urandom_range(0, 4)];
            wb_data = {$urandom, $urandom};
            rs1_addr = addr_pool[$urandom_range(0, 4)];
            rs2_addr = addr_pool[$urandom_range(0, 4)];
            rs1_data = {$urandom, $urandom};
            rs2_data = {$urandom, $urandom};
            imm = {$urandom, $urandom};
            alu_src = $urandom_range(0, 1);
            alu_op = 2'($urandom_range(0, 3));
            opcode = ($urandom_range(0, 3) != 0) ? opcs[$urandom_range(0, 3)] : 11'($urandom);
            rd_addr = 5'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
